// File: rtl/rca_ft_pkg.sv
// Shared definitions for the ripple-carry adder fault-tolerance BIST controller:
// datapath width, FSM state encoding and the default settle time.
package rca_ft_pkg;

    localparam int NUM_BITS              = 4;
    localparam int SETTLE_CYCLES_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_CHECK,
        ST_EVAL,
        ST_DONE
    } bistState_e;

    // A single failing cell is repairable; zero or several failing cells are not one-hot.
    function automatic logic isOneHot(input logic [2*NUM_BITS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/rca_ft_bist_ctrl_if.sv
// Bundle between the BIST controller (master) and the adder under test / system (slave).
interface rca_ft_bist_ctrl_if;
    import rca_ft_pkg::*;

    logic                start;
    logic                test;
    logic [NUM_BITS:0]   TA;
    logic [NUM_BITS:0]   TB;
    logic [NUM_BITS-1:0] st;
    logic [NUM_BITS-1:0] ct;
    logic [NUM_BITS:0]   CS;
    logic [NUM_BITS-1:0] SS;
    logic                busy;
    logic                done;
    logic                fault_found;
    logic                uncorrectable;

    modport master (
        input  start, st, ct,
        output test, TA, TB, CS, SS, busy, done, fault_found, uncorrectable
    );

    modport slave (
        output start, st, ct,
        input  test, TA, TB, CS, SS, busy, done, fault_found, uncorrectable
    );

endinterface

// File: rtl/rca_ft_bist_expect.sv
// Golden reference for one test pattern: per-cell sum bits and carry-outs of a+b with cin=0.
module rca_ft_bist_expect
    import rca_ft_pkg::*;
(
    input  logic [NUM_BITS-1:0] a_i,
    input  logic [NUM_BITS-1:0] b_i,
    output logic [NUM_BITS-1:0] expSum_o,
    output logic [NUM_BITS-1:0] expCarry_o
);

    logic [NUM_BITS:0] carry;

    // carry[i] is the carry into cell i, carry[i+1] its carry-out.
    always_comb begin
        carry    = '0;
        expSum_o = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            expSum_o[i]  = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign expCarry_o = carry[NUM_BITS:1];

endmodule

// File: rtl/rca_ft_bist_ctrl.sv
// Exhaustive self-test of a 4-bit ripple-carry adder: runs all 256 operand pairs,
// accumulates sticky per-cell error masks, then selects a spare cell if exactly one failed.
module rca_ft_bist_ctrl
    import rca_ft_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    rca_ft_bist_ctrl_if.master bus
);

    bistState_e            state_q;
    logic [2*NUM_BITS-1:0] cnt_q;
    logic [3:0]            wait_q;
    logic [NUM_BITS-1:0]   sumErr_q;
    logic [NUM_BITS-1:0]   carryErr_q;
    logic [NUM_BITS:0]     ta_q;
    logic [NUM_BITS:0]     tb_q;
    logic [NUM_BITS:0]     cs_q;
    logic [NUM_BITS-1:0]   ss_q;
    logic                  test_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  faultFound_q;
    logic                  uncorrectable_q;

    logic [NUM_BITS-1:0]   expSum;
    logic [NUM_BITS-1:0]   expCarry;
    logic [NUM_BITS-1:0]   sumErr_d;
    logic [NUM_BITS-1:0]   carryErr_d;
    logic [2*NUM_BITS-1:0] cnt_d;
    logic [2*NUM_BITS-1:0] errAll;

    rca_ft_bist_expect u_expect (
        .a_i        (cnt_q[NUM_BITS-1:0]),
        .b_i        (cnt_q[2*NUM_BITS-1:NUM_BITS]),
        .expSum_o   (expSum),
        .expCarry_o (expCarry)
    );

    assign sumErr_d   = sumErr_q   | (bus.st ^ expSum);
    assign carryErr_d = carryErr_q | (bus.ct ^ expCarry);
    assign cnt_d      = cnt_q + 1'b1;
    assign errAll     = {carryErr_q, sumErr_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            wait_q          <= '0;
            sumErr_q        <= '0;
            carryErr_q      <= '0;
            ta_q            <= '0;
            tb_q            <= '0;
            cs_q            <= '0;
            ss_q            <= '0;
            test_q          <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            faultFound_q    <= 1'b0;
            uncorrectable_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_q         <= ST_APPLY;
                        cnt_q           <= '0;
                        sumErr_q        <= '0;
                        carryErr_q      <= '0;
                        ta_q            <= '0;
                        tb_q            <= '0;
                        cs_q            <= '0;
                        ss_q            <= '0;
                        test_q          <= 1'b1;
                        busy_q          <= 1'b1;
                        done_q          <= 1'b0;
                        faultFound_q    <= 1'b0;
                        uncorrectable_q <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    state_q <= ST_WAIT;
                    wait_q  <= 4'(SETTLE_CYCLES - 1);
                end
                ST_WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= ST_CHECK;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                ST_CHECK: begin
                    sumErr_q   <= sumErr_d;
                    carryErr_q <= carryErr_d;
                    // Operands change only here, so they stay stable across APPLY..CHECK.
                    if (cnt_q == '1) begin
                        state_q <= ST_EVAL;
                    end else begin
                        state_q <= ST_APPLY;
                        cnt_q   <= cnt_d;
                        ta_q    <= {1'b0, cnt_d[NUM_BITS-1:0]};
                        tb_q    <= {1'b0, cnt_d[2*NUM_BITS-1:NUM_BITS]};
                    end
                end
                ST_EVAL: begin
                    state_q <= ST_DONE;
                    test_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    ta_q    <= '0;
                    tb_q    <= '0;
                    if (errAll == '0) begin
                        faultFound_q <= 1'b0;
                    end else if (isOneHot(errAll)) begin
                        faultFound_q <= 1'b1;
                        ss_q         <= sumErr_q;
                        cs_q         <= {1'b0, carryErr_q};
                    end else begin
                        faultFound_q    <= 1'b1;
                        uncorrectable_q <= 1'b1;
                        ss_q            <= '0;
                        cs_q            <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.test          = test_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.TA            = ta_q;
    assign bus.TB            = tb_q;
    assign bus.CS            = cs_q;
    assign bus.SS            = ss_q;
    assign bus.fault_found   = faultFound_q;
    assign bus.uncorrectable = uncorrectable_q;

endmodule
